// File: rtl/idc_arbiter.sv
// Round-robin arbiter that shares one ID-check engine among NUM_REQ requesters:
// it screens the winner's ID, streams it field by field, and returns the verdict.
module idc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_LEN  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ID_LEN*6-1:0] req_id,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic                        resp_legal,
  output logic                        resp_err,
  output logic                        chk_in_valid,
  output logic [5:0]                  chk_in_id,
  input  logic                        chk_out_valid,
  input  logic                        chk_out_legal
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = ID_LEN * 6;
  localparam int KW = $clog2(ID_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RESP, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     w_q, w_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_d, resp_valid_d;
  logic              resp_legal_d, resp_err_d, chk_in_valid_d;
  logic [5:0]        chk_in_id_d;

  logic              found;
  int unsigned       sel;
  int unsigned       idx;
  logic [NUM_REQ-1:0] req_sh;
  logic [BW-1:0]     sel_id;
  logic              screen_ok;

  // Round-robin search starting at the rr pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    sel    = 0;
    idx    = 0;
    req_sh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx    = (32'(rr_q) + i) % NUM_REQ;
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    sel_id    = BW'(req_id >> (sel * BW));
    screen_ok = (sel_id[5:0] >= 6'd10) && (sel_id[5:0] <= 6'd35);
    for (int unsigned k = 1; k < ID_LEN; k++) begin
      if (6'(sel_id >> (6 * k)) > 6'd9) screen_ok = 1'b0;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    w_d            = w_q;
    buf_d          = buf_q;
    k_d            = k_q;
    cnt_d          = cnt_q;
    grant_d        = '0;
    resp_valid_d   = '0;
    resp_legal_d   = 1'b0;
    resp_err_d     = 1'b0;
    chk_in_valid_d = 1'b0;
    chk_in_id_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          w_d     = IW'(sel);
          rr_d    = IW'((sel + 1) % NUM_REQ);
          buf_d   = sel_id;
          grant_d = ONE_HOT0 << sel;
          if (screen_ok) begin
            // Field 0 goes out together with grant.
            state_d        = S_SEND;
            chk_in_valid_d = 1'b1;
            chk_in_id_d    = sel_id[5:0];
            k_d            = KW'(1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_SEND: begin
        if (k_q == KW'(ID_LEN)) begin
          state_d = S_WAIT;
          cnt_d   = TW'(1);
        end else begin
          chk_in_valid_d = 1'b1;
          chk_in_id_d    = 6'(buf_q >> (6 * 32'(k_q)));
          k_d            = k_q + KW'(1);
        end
      end
      S_WAIT: begin
        if (chk_out_valid) begin
          state_d      = S_RESP;
          resp_valid_d = ONE_HOT0 << w_q;
          resp_legal_d = chk_out_legal;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          state_d      = S_RESP;
          resp_valid_d = ONE_HOT0 << w_q;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_RESP: begin
        // Entered with resp_valid low only from a screen reject: issue it now.
        if (resp_valid == '0) begin
          resp_valid_d = ONE_HOT0 << w_q;
          resp_err_d   = 1'b1;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      w_q          <= '0;
      buf_q        <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      grant        <= '0;
      resp_valid   <= '0;
      resp_legal   <= 1'b0;
      resp_err     <= 1'b0;
      chk_in_valid <= 1'b0;
      chk_in_id    <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      w_q          <= w_d;
      buf_q        <= buf_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      grant        <= grant_d;
      resp_valid   <= resp_valid_d;
      resp_legal   <= resp_legal_d;
      resp_err     <= resp_err_d;
      chk_in_valid <= chk_in_valid_d;
      chk_in_id    <= chk_in_id_d;
    end
  end

endmodule

// File: tb/tb_idc_arbiter.sv
// Self-checking bench for idc_arbiter: randomized traffic against a transaction
// schedule model, plus directed latency, rotation, reject, timeout and reset scenarios.
module tb_idc_arbiter;

  localparam int NR = 4;
  localparam int IL = 10;
  localparam int TO = 16;
  localparam int BW = IL * 6;

  typedef struct packed { int c; logic [3:0] v; logic l; logic e; } ev_t;
  typedef struct packed { int c; logic [5:0] id; } st_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*BW-1:0] req_id = '0;
  logic [NR-1:0]   grant, resp_valid;
  logic            resp_legal, resp_err, chk_in_valid;
  logic [5:0]      chk_in_id;
  logic            chk_out_valid = 1'b0;
  logic            chk_out_legal = 1'b0;

  logic [BW-1:0]   idp [NR];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int viol = 0;
  bit stub_silent = 1'b0;
  bit stub_noise = 1'b0;
  ev_t gq[$];
  ev_t rq[$];
  st_t sq[$];

  idc_arbiter #(.NUM_REQ(NR), .ID_LEN(IL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_id(req_id),
    .grant(grant), .resp_valid(resp_valid), .resp_legal(resp_legal), .resp_err(resp_err),
    .chk_in_valid(chk_in_valid), .chk_in_id(chk_in_id),
    .chk_out_valid(chk_out_valid), .chk_out_legal(chk_out_legal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] fld(input logic [BW-1:0] p, input int k);
    return p[k*6 +: 6];
  endfunction

  // Letter code splits into two decimal digits; weights 1,9,8,...,1 then the check digit.
  function automatic bit taiwan_ok(input logic [BW-1:0] p);
    int s;
    s = int'(fld(p, 0)) / 10 + (int'(fld(p, 0)) % 10) * 9;
    for (int i = 1; i < IL - 1; i++) s += int'(fld(p, i)) * (IL - 1 - i);
    s += int'(fld(p, IL - 1));
    return (s % 10) == 0;
  endfunction

  function automatic bit screen_pass(input logic [BW-1:0] p);
    bit ok;
    ok = (fld(p, 0) >= 6'd10) && (fld(p, 0) <= 6'd35);
    for (int i = 1; i < IL; i++) if (fld(p, i) > 6'd9) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [BW-1:0] base_id();
    logic [BW-1:0] p;
    p = '0;
    p[5:0] = 6'd10;
    for (int i = 1; i < IL; i++) p[i*6 +: 6] = 6'(i);
    return p;
  endfunction

  task automatic gen_id(input int r);
    logic [BW-1:0] p;
    int cls, k;
    bit hit;
    p = '0;
    p[5:0] = 6'($urandom_range(10, 35));
    for (int i = 1; i < IL - 1; i++) p[i*6 +: 6] = 6'($urandom_range(0, 9));
    hit = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!hit) begin
        p[(IL-1)*6 +: 6] = 6'(c);
        hit = taiwan_ok(p);
      end
    end
    cls = $urandom_range(0, 9);
    if (cls >= 4 && cls <= 6) begin
      p[(IL-1)*6 +: 6] = 6'((int'(fld(p, IL - 1)) + $urandom_range(1, 9)) % 10);
    end else if (cls >= 7) begin
      k = $urandom_range(0, IL - 1);
      if (k == 0) p[5:0] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(36, 63));
      else p[k*6 +: 6] = 6'($urandom_range(10, 63));
    end
    idp[r] = p;
  endtask

  task automatic pack();
    for (int r = 0; r < NR; r++) req_id[r*BW +: BW] = idp[r];
  endtask

  task automatic clear_logs();
    gq.delete();
    rq.delete();
    sq.delete();
  endtask

  task automatic serve(input logic [NR-1:0] mask, input int budget, output bit to);
    logic [NR-1:0] done;
    done = '0;
    pack();
    @(negedge clk);
    req = req | mask;
    for (int n = 0; n < budget && done != mask; n++) begin
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
        if (resp_valid[r] && mask[r]) begin
          req[r] = 1'b0;
          done[r] = 1'b1;
        end
      end
    end
    to = (done != mask);
    #1;
  endtask

  // Checker stand-in: verdict two cycles after the last field; optional noise during the stream.
  int s_cnt = 0;
  int s_pend = 0;
  logic [BW-1:0] s_buf = '0;
  bit s_verdict = 1'b0;
  always @(negedge clk) begin
    chk_out_valid = 1'b0;
    chk_out_legal = 1'b0;
    if (rst) begin
      s_cnt = 0;
      s_pend = 0;
    end else begin
      if (s_pend > 0) begin
        s_pend--;
        if (s_pend == 0) begin
          chk_out_valid = 1'b1;
          chk_out_legal = s_verdict;
        end
      end
      if (chk_in_valid) begin
        s_buf[s_cnt*6 +: 6] = chk_in_id;
        s_cnt++;
        if (s_cnt == IL) begin
          s_verdict = taiwan_ok(s_buf);
          s_cnt = 0;
          if (!stub_silent) s_pend = 2;
        end else if (stub_noise && $urandom_range(0, 3) == 0) begin
          chk_out_valid = 1'b1;
          chk_out_legal = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (grant != '0) gq.push_back('{c: cyc, v: grant, l: 1'b0, e: 1'b0});
      if (resp_valid != '0) rq.push_back('{c: cyc, v: resp_valid, l: resp_legal, e: resp_err});
      if (chk_in_valid) sq.push_back('{c: cyc, id: chk_in_id});
      if (resp_valid == '0 && (resp_legal || resp_err)) viol++;
      if ($countones(grant) > 1 || $countones(resp_valid) > 1) viol++;
      if (!chk_in_valid && chk_in_id != 6'd0) viol++;
    end
  end

  task automatic test_reset();
    logic [NR*2+9:0] o;
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    o = {grant, resp_valid, resp_legal, resp_err, chk_in_valid, chk_in_id};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", o); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    o = {grant, resp_valid, resp_legal, resp_err, chk_in_valid, chk_in_id};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL idle_outputs got=%h exp=0", o); end
  endtask

  task automatic test_random_traffic();
    int free_c, g_c, r_c, w, rrm, c;
    int hold [NR];
    bit has_tx, ok_t, e_legal, picked;
    logic [BW-1:0] pm;
    logic [NR-1:0] eg, erv;
    logic ecv, el, ee;
    logic [5:0] ecid;
    stub_noise = 1'b1;
    stub_silent = 1'b0;
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    has_tx = 1'b0; free_c = 0; rrm = 0; g_c = 0; r_c = 0; w = 0; ok_t = 1'b0; e_legal = 1'b0; pm = '0;
    for (int r = 0; r < NR; r++) hold[r] = 0;
    repeat (1500) begin
      @(negedge clk);
      c = cyc;
      eg   = (has_tx && c == g_c) ? NR'(1) << w : '0;
      ecv  = has_tx && ok_t && c >= g_c && c < g_c + IL;
      ecid = ecv ? fld(pm, c - g_c) : 6'd0;
      erv  = (has_tx && c == r_c) ? NR'(1) << w : '0;
      el   = (erv != '0) && e_legal;
      ee   = (erv != '0) && !ok_t;
      checks++;
      if (grant !== eg) begin errors++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", c, grant, eg); end
      checks++;
      if ({chk_in_valid, chk_in_id} !== {ecv, ecid}) begin
        errors++; $display("FAIL rand_stream cyc=%0d got=%b/%0d exp=%b/%0d", c, chk_in_valid, chk_in_id, ecv, ecid);
      end
      checks++;
      if ({resp_valid, resp_legal, resp_err} !== {erv, el, ee}) begin
        errors++; $display("FAIL rand_resp cyc=%0d got=%b/%b/%b exp=%b/%b/%b", c, resp_valid, resp_legal, resp_err, erv, el, ee);
      end
      for (int r = 0; r < NR; r++) begin
        if (has_tx && c == r_c && r == w) begin
          req[r] = 1'b0;
          hold[r] = $urandom_range(3, 8);
        end else if (req[r]) begin
          if (has_tx && r == w && c > g_c && c < r_c && $urandom_range(0, 29) == 0) begin
            req[r] = 1'b0;
            hold[r] = 20;
          end
        end else if (hold[r] > 0) begin
          hold[r]--;
        end else if ($urandom_range(0, 7) == 0) begin
          gen_id(r);
          req[r] = 1'b1;
        end
      end
      pack();
      if (c >= free_c && req != '0) begin
        picked = 1'b0;
        for (int i = 0; i < NR; i++) begin
          if (!picked && req[(rrm + i) % NR]) begin
            picked = 1'b1;
            w = (rrm + i) % NR;
          end
        end
        rrm = (w + 1) % NR;
        pm = idp[w];
        ok_t = screen_pass(pm);
        e_legal = ok_t && taiwan_ok(pm);
        g_c = c + 1;
        r_c = ok_t ? g_c + IL + 2 : g_c + 1;
        free_c = r_c + 2;
        has_tx = 1'b1;
      end
    end
    req = '0;
    repeat (40) @(negedge clk);
    stub_noise = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_id(input logic [5:0] last, input bit exp_legal, input string nm);
    bit to, ok;
    int t;
    ev_t ge, re, rx;
    logic [BW-1:0] p;
    p = base_id();
    p[(IL-1)*6 +: 6] = last;
    idp[0] = p;
    clear_logs();
    serve(4'b0001, 60, to);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout got=%0d exp=0", nm, to); end
    ge = (gq.size() > 0) ? gq[0] : '0;
    t = ge.c;
    checks++;
    if (gq.size() != 1 || ge.v !== 4'b0001) begin
      errors++; $display("FAIL %s_grant got=%0d/%b exp=1/0001", nm, gq.size(), ge.v);
    end
    ok = (sq.size() == IL);
    for (int k = 0; k < sq.size() && k < IL; k++) if (sq[k].c != t + k || sq[k].id !== fld(p, k)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_stream got=%0d fields exp=%0d in order from cycle %0d", nm, sq.size(), IL, t); end
    re = (rq.size() > 0) ? rq[0] : '0;
    rx = '{c: t + 12, v: 4'b0001, l: exp_legal, e: 1'b0};
    checks++;
    if (rq.size() != 1 || re !== rx) begin
      errors++; $display("FAIL %s_resp got=cyc%0d/%b/%b/%b exp=cyc%0d/0001/%b/0", nm, re.c, re.v, re.l, re.e, t + 12, exp_legal);
    end
  endtask

  task automatic test_back_to_back();
    bit to, ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < NR; r++) idp[r] = base_id();
    clear_logs();
    serve(4'b1111, 200, to);
    ok = !to && gq.size() == 4 && rq.size() == 4;
    for (int i = 0; i < 4 && ok; i++) begin
      if (gq[i].v !== 4'(1 << i)) ok = 1'b0;
      if (i > 0 && gq[i].c != gq[i-1].c + 15) ok = 1'b0;
      if (rq[i].c != gq[i].c + 12 || rq[i].v !== gq[i].v || rq[i].l !== 1'b1 || rq[i].e !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_order got=%0d grants %0d resps exp=4 grants r0..r3 15 apart, all legal", gq.size(), rq.size()); end
  endtask

  task automatic test_rotation();
    bit to;
    logic [11:0] got;
    for (int r = 0; r < NR; r++) idp[r] = base_id();
    clear_logs();
    pack();
    @(negedge clk);
    req = 4'b0100;
    repeat (5) @(negedge clk);
    serve(4'b1101, 200, to);
    got = '0;
    for (int i = 0; i < 3 && i < gq.size(); i++) got[i*4 +: 4] = gq[i].v;
    checks++;
    if (to || gq.size() != 3 || got !== 12'b0001_1000_0100) begin
      errors++; $display("FAIL rotation got=%0d grants %b exp=3 grants 0001_1000_0100", gq.size(), got);
    end
  endtask

  task automatic test_reject();
    bit to;
    ev_t ge, re, rx;
    logic [BW-1:0] p;
    p = base_id();
    p[3*6 +: 6] = 6'd12;
    idp[1] = p;
    clear_logs();
    serve(4'b0010, 30, to);
    ge = (gq.size() > 0) ? gq[0] : '0;
    checks++;
    if (to || gq.size() != 1 || ge.v !== 4'b0010) begin errors++; $display("FAIL reject_grant got=%0d/%b exp=1/0010", gq.size(), ge.v); end
    re = (rq.size() > 0) ? rq[0] : '0;
    rx = '{c: ge.c + 1, v: 4'b0010, l: 1'b0, e: 1'b1};
    checks++;
    if (rq.size() != 1 || re !== rx) begin
      errors++; $display("FAIL reject_resp got=cyc%0d/%b/%b/%b exp=cyc%0d/0010/0/1", re.c, re.v, re.l, re.e, ge.c + 1);
    end
    checks++;
    if (sq.size() != 0) begin errors++; $display("FAIL reject_no_stream got=%0d fields exp=0", sq.size()); end
  endtask

  task automatic test_timeout();
    bit to;
    ev_t ge, re, rx;
    stub_silent = 1'b1;
    idp[0] = base_id();
    clear_logs();
    serve(4'b0001, 80, to);
    stub_silent = 1'b0;
    ge = (gq.size() > 0) ? gq[0] : '0;
    re = (rq.size() > 0) ? rq[0] : '0;
    rx = '{c: ge.c + IL + TO, v: 4'b0001, l: 1'b0, e: 1'b1};
    checks++;
    if (to || rq.size() != 1 || sq.size() != IL || re !== rx) begin
      errors++; $display("FAIL timeout_resp got=cyc%0d/%b/%b/%b fields=%0d exp=cyc%0d/0001/0/1 fields=%0d",
                         re.c, re.v, re.l, re.e, sq.size(), ge.c + IL + TO, IL);
    end
  endtask

  task automatic test_reset_mid_send();
    bit to, ok;
    int n, cnt, t;
    logic [NR*2+9:0] o;
    idp[0] = base_id();
    clear_logs();
    pack();
    @(negedge clk);
    req = 4'b0001;
    n = 0;
    cnt = 0;
    while (n < 40 && cnt < 6) begin
      @(negedge clk);
      if (chk_in_valid) cnt++;
      n++;
    end
    checks++;
    if (cnt != 6 || chk_in_id !== 6'd5) begin errors++; $display("FAIL midsend_reach got=%0d/%0d exp=6/5", cnt, chk_in_id); end
    rst = 1'b1;
    #1;
    o = {grant, resp_valid, resp_legal, resp_err, chk_in_valid, chk_in_id};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL midsend_reset_outputs got=%h exp=0", o); end
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < NR; r++) idp[r] = base_id();
    clear_logs();
    serve(4'b1111, 200, to);
    t = (gq.size() > 0) ? gq[0].c : 0;
    ok = !to && gq.size() == 4 && gq[0].v === 4'b0001 && sq.size() >= IL;
    for (int k = 0; k < IL && ok; k++) if (sq[k].c != t + k || sq[k].id !== fld(idp[0], k)) ok = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL midsend_restart got=%0d grants first=%b fields=%0d exp=grant 0001 then %0d fields",
                                      gq.size(), (gq.size() > 0) ? gq[0].v : 4'b0, sq.size(), IL); end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL onehot_and_idle_zero got=%0d violations exp=0", viol); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=no finish exp=finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++) idp[r] = '0;
    test_reset();
    test_random_traffic();
    test_single_id(6'd9, 1'b1, "legal");
    test_single_id(6'd8, 1'b0, "badcheck");
    test_back_to_back();
    test_rotation();
    test_reject();
    test_timeout();
    test_reset_mid_send();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idc_arbiter.md
Name: idc_arbiter

Overview:
- Shares one ID-check engine among NUM_REQ requesters.
- Each requester presents a complete 10-field ID in parallel. The arbiter picks a winner round-robin, screens the fields, and streams them one per cycle into the checker. It then waits for the verdict with a timeout and returns legal/error status to the winner.
- Sits between the host-side request ports and the single IDC checker instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_LEN, 10, fields per ID (field 0 = letter code, fields 1..ID_LEN-1 = decimal digits, last = check digit)
- TIMEOUT, 16, max WAIT cycles for checker verdict before error (>=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request per requester; held until its resp_valid
- req_id  in  NUM_REQ*ID_LEN*6  packed IDs; requester r field k at bits [(r*ID_LEN+k)*6 +: 6]
- grant  out  NUM_REQ  one-hot, 1-cycle pulse when requester is accepted
- resp_valid  out  NUM_REQ  one-hot, 1-cycle pulse carrying result
- resp_legal  out  1  verdict, valid with resp_valid
- resp_err  out  1  1 = rejected (bad field) or timeout, valid with resp_valid
- chk_in_valid  out  1  to checker in_valid
- chk_in_id  out  6  to checker in_id
- chk_out_valid  in  1  from checker out_valid
- chk_out_legal  in  1  from checker out_legal_id

Behaviour:
- Reset (async, any state): state=IDLE; rr pointer=0; grant, resp_valid, resp_legal, resp_err, chk_in_valid, chk_in_id=0. A stream in flight is abandoned; chk_in_valid drops immediately.
- All outputs are registered.
- States: IDLE, SEND, WAIT, RESP, GAP.
- IDLE:
  - On a clock edge with any req high, select the first requester with req high, searching from the rr pointer upward (wrapping).
  - Latch its ID into an internal buffer, pulse grant[w] next cycle, and set rr pointer=w+1 mod NUM_REQ.
  - Field screen on the latched ID: field0 must be 10..35; fields 1..ID_LEN-1 must be 0..9.
  - Screen pass: SEND, and the grant cycle is the first SEND cycle.
  - Screen fail: RESP with err=1, legal=0, and the checker is never driven.
- SEND: ID_LEN consecutive cycles with chk_in_valid=1 and chk_in_id=field k, k=0..ID_LEN-1 in order. Then WAIT with chk_in_valid=0, chk_in_id=0.
- WAIT:
  - Cycle counter starts at 1.
  - On an edge sampling chk_out_valid=1: capture chk_out_legal, err=0, go to RESP.
  - If the counter reaches TIMEOUT without chk_out_valid: legal=0, err=1, go to RESP.
- RESP: resp_valid[w]=1 for one cycle with resp_legal/resp_err. Then GAP.
- GAP: one idle cycle so the checker returns to its start index. Then IDLE.
  - req sampled in GAP is ignored.
  - The requester must drop req in the cycle after resp_valid, or it will be re-arbitrated in the next IDLE.
- Latency with a checker whose out_valid rises 2 cycles after the last digit cycle:
  - grant in cycle T, digits T..T+9, resp_valid at T+12.
  - Next grant no earlier than T+15.
- Rejected ID: grant at T, resp_valid at T+1.
- chk_out_valid seen in IDLE/SEND/RESP/GAP: ignored, and it does not alter the verdict.
- Requester dropping req mid-transaction: the transaction completes normally and the response is still delivered.
- resp_legal/resp_err return to 0 when resp_valid is low.
- Only one transaction at a time; the grant and resp_valid one-hots never have more than one bit set.

Test Plan:
- Single request r0, ID {10,1,2,3,4,5,6,7,8,9} with a behavioural checker (sum=121, check digit 9) -> grant[0] at T; chk_in_id 10,1,..,9 on T..T+9; resp_valid[0] at T+12 with legal=1, err=0.
- Same ID with last digit 8 -> resp_valid[0] at T+12, legal=0, err=0.
- req=4'b1111 held, all IDs legal -> grants in order r0,r1,r2,r3, each 15 cycles apart.
- Re-raise r0 while r2 is served -> after r2 the order is r3 then r0 (rotation, no starvation).
- r1 ID field3=12 -> grant[1] at T, resp_valid[1] at T+1 with err=1, legal=0; chk_in_valid stays 0 throughout.
- Checker stub never asserts chk_out_valid (TIMEOUT=16) -> resp_valid at T+10+16 with err=1.
- Assert rst mid-SEND at digit 5 -> all outputs 0 same cycle; after release, a new request gets grant[0] and a full 10-digit stream.
